// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the pc_fetch program-counter stage.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int PC_STEP     = 4;
  localparam int BR_SHIFT    = 2;
  localparam int FETCH_CNT_W = 16;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-side bus of pc_fetch. With PC_REDIRECT_TRACE_EN defined, it also
// carries the redirect trace outputs.
interface pc_fetch_if
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic                   en;
  logic                   branch_taken;
  logic [15:0]            branch_offset;
  logic                   jump;
  logic [25:0]            jump_target;
  logic [31:0]            instr_in;
  logic [ADDR_W-1:0]      pc_addr;
  logic [ADDR_W-1:0]      pc_plus4;
  logic [31:0]            instr_out;
  logic                   instr_valid;
  logic                   halted;
  logic [FETCH_CNT_W-1:0] fetch_count;
`ifdef PC_REDIRECT_TRACE_EN
  logic [ADDR_W-1:0]      last_redirect_pc;
  logic [7:0]             redirect_count;
`endif

  modport master (
    output en, branch_taken, branch_offset, jump, jump_target, instr_in,
`ifdef PC_REDIRECT_TRACE_EN
    input  last_redirect_pc, redirect_count,
`endif
    input  pc_addr, pc_plus4, instr_out, instr_valid, halted, fetch_count
  );

  modport slave (
    input  en, branch_taken, branch_offset, jump, jump_target, instr_in,
`ifdef PC_REDIRECT_TRACE_EN
    output last_redirect_pc, redirect_count,
`endif
    output pc_addr, pc_plus4, instr_out, instr_valid, halted, fetch_count
  );

endinterface

// File: rtl/pc_fetch_next_pc_calc.sv
// Combinational next-PC selection: jump over taken branch over sequential.
module next_pc_calc
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_jump,
  input  logic [25:0]       i_jump_target,
  input  logic              i_branch_taken,
  input  logic [15:0]       i_branch_offset,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic [ADDR_W-1:0] o_pc_plus4
);

  logic [31:0]       w_br_ext;
  logic [27:0]       w_jmp_full;
  logic [ADDR_W-1:0] w_br_target;
  logic              w_unused_bits;

  assign o_pc_plus4  = i_pc + ADDR_W'(PC_STEP);
  assign w_br_ext    = {{16{i_branch_offset[15]}}, i_branch_offset} << BR_SHIFT;
  // All arithmetic is truncated to ADDR_W, so targets wrap around the address space.
  assign w_br_target = o_pc_plus4 + w_br_ext[ADDR_W-1:0];
  assign w_jmp_full  = {i_jump_target, 2'b00};

  always_comb begin
    o_next_pc = o_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_jmp_full[ADDR_W-1:0];
    end else if (i_branch_taken) begin
      o_next_pc = w_br_target;
    end
  end

  assign w_unused_bits = ^{w_br_ext[31:ADDR_W], w_jmp_full[27:ADDR_W]};

endmodule

// File: rtl/pc_fetch.sv
// PC register, run/stall/halt FSM and fetch counter of the MIPS fetch stage.
// Defining PC_REDIRECT_TRACE_EN adds last-redirect PC and redirect-count tracing.
//
// state | meaning
// RUN   | fetching; PC advances whenever en=1
// STALL | en was low; PC, counters and trace hold
// HALT  | next PC reached HALT_ADDR; only rst leaves
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 8'h2C
) (
  input  logic     i_clk,
  input  logic     i_rst,
  pc_fetch_if.slave bus
);

  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_STALL = ST_STALL;
  localparam logic [1:0] S_HALT  = ST_HALT;

  logic [1:0]             r_state;
  logic [ADDR_W-1:0]      r_pc;
  logic [FETCH_CNT_W-1:0] r_fetch_count;
  logic [ADDR_W-1:0]      w_next_pc;
  logic [ADDR_W-1:0]      w_pc_plus4;
  logic                   w_load;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
    .i_pc            (r_pc),
    .i_jump          (bus.jump),
    .i_jump_target   (bus.jump_target),
    .i_branch_taken  (bus.branch_taken),
    .i_branch_offset (bus.branch_offset),
    .o_next_pc       (w_next_pc),
    .o_pc_plus4      (w_pc_plus4)
  );

  assign w_load = bus.en && (r_state != S_HALT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else if (w_load) begin
      r_pc    <= w_next_pc;
      r_state <= (w_next_pc == HALT_ADDR) ? S_HALT : S_RUN;
      // The resume cycle out of STALL moves the PC but is not a counted fetch.
      if ((r_state == S_RUN) && (r_fetch_count != '1)) begin
        r_fetch_count <= r_fetch_count + 1'b1;
      end
    end else if (r_state != S_HALT) begin
      r_state <= S_STALL;
    end
  end

`ifdef PC_REDIRECT_TRACE_EN
  logic [ADDR_W-1:0] r_last_redirect_pc;
  logic [7:0]        r_redirect_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_redirect_pc <= '0;
      r_redirect_count   <= '0;
    end else if (w_load && (bus.jump || bus.branch_taken)) begin
      r_last_redirect_pc <= r_pc;
      r_redirect_count   <= r_redirect_count + 8'd1;
    end
  end

  assign bus.last_redirect_pc = r_last_redirect_pc;
  assign bus.redirect_count   = r_redirect_count;
`endif

  assign bus.pc_addr     = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.instr_out   = bus.instr_in;
  assign bus.instr_valid = (r_state == S_RUN) && bus.en && !i_rst;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with hand-computed expectations.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_fetch_if #(.ADDR_W(8)) bus ();

  pc_fetch #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_ADDR(8'h2C)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic br, input logic [15:0] off,
                       input logic j, input logic [25:0] tgt);
    bus.en            = en;
    bus.branch_taken  = br;
    bus.branch_offset = off;
    bus.jump          = j;
    bus.jump_target   = tgt;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] pc, input logic valid,
                        input logic halted);
    chk({tag, "_pc"}, 32'(bus.pc_addr), 32'(pc));
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(valid));
    chk({tag, "_halted"}, 32'(bus.halted), 32'(halted));
  endtask

  task automatic chk_trace(input string tag, input logic [7:0] last, input logic [7:0] cnt);
`ifdef PC_REDIRECT_TRACE_EN
    chk({tag, "_last_redir"}, 32'(bus.last_redirect_pc), 32'(last));
    chk({tag, "_redir_cnt"}, 32'(bus.redirect_count), 32'(cnt));
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.instr_in = 32'h0;
    drive(1'b1, 1'b1, 16'h0004, 1'b1, 26'h3);
    tick();
    tick();
    chk_st("reset", 8'h00, 1'b0, 1'b0);
    chk("reset_fc", 32'(bus.fetch_count), 32'd0);
    chk_trace("reset", 8'h00, 8'h00);

    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    bus.instr_in = 32'hDEADBEEF;
    #1;
    chk_st("seq0", 8'h00, 1'b1, 1'b0);
    chk("seq0_fc", 32'(bus.fetch_count), 32'd0);
    chk("instr_pass", bus.instr_out, 32'hDEADBEEF);
    chk("seq0_plus4", 32'(bus.pc_plus4), 32'h04);
    tick();
    chk_st("seq1", 8'h04, 1'b1, 1'b0);
    chk("seq1_fc", 32'(bus.fetch_count), 32'd1);
    tick();
    chk_st("seq2", 8'h08, 1'b1, 1'b0);
    chk("seq2_fc", 32'(bus.fetch_count), 32'd2);
    tick();
    chk_st("seq3", 8'h0C, 1'b1, 1'b0);
    chk("seq3_fc", 32'(bus.fetch_count), 32'd3);
    tick();
    chk_st("seq4", 8'h10, 1'b1, 1'b0);

    // 0x10: branch +4 words -> 0x14 + 0x10 = 0x24
    drive(1'b1, 1'b1, 16'h0004, 1'b0, 26'h0);
    tick();
    chk_st("branch", 8'h24, 1'b1, 1'b0);
    chk("branch_fc", 32'(bus.fetch_count), 32'd5);
    chk_trace("branch", 8'h10, 8'd1);

    drive(1'b1, 1'b0, 16'h0, 1'b1, 26'h8);
    tick();
    chk_st("jump20", 8'h20, 1'b1, 1'b0);
    chk("jump20_fc", 32'(bus.fetch_count), 32'd6);
    chk_trace("jump20", 8'h24, 8'd2);

    drive(1'b1, 1'b1, 16'h0008, 1'b1, 26'h4);
    bus.instr_in = 32'h1234_5678;
    #1;
    chk("instr_pass2", bus.instr_out, 32'h1234_5678);
    tick();
    chk_st("jump_wins", 8'h10, 1'b1, 1'b0);
    chk("jump_wins_fc", 32'(bus.fetch_count), 32'd7);
    chk_trace("jump_wins", 8'h20, 8'd3);

    drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    tick();
    chk_st("to14", 8'h14, 1'b1, 1'b0);
    chk("to14_fc", 32'(bus.fetch_count), 32'd8);

    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h0);
    #1;
    chk("stall_valid0", 32'(bus.instr_valid), 32'd0);
    repeat (3) begin
      tick();
      chk_st("stall", 8'h14, 1'b0, 1'b0);
      chk("stall_fc", 32'(bus.fetch_count), 32'd8);
      chk_trace("stall", 8'h20, 8'd3);
    end

    drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    #1;
    chk("resume_valid0", 32'(bus.instr_valid), 32'd0);
    tick();
    chk_st("resume", 8'h18, 1'b1, 1'b0);
    tick();
    chk_st("seq1c", 8'h1C, 1'b1, 1'b0);
    tick();
    chk_st("seq20", 8'h20, 1'b1, 1'b0);
    tick();
    chk_st("seq24", 8'h24, 1'b1, 1'b0);
    tick();
    chk_st("seq28", 8'h28, 1'b1, 1'b0);
    tick();
    chk_st("halt", 8'h2C, 1'b0, 1'b1);

    drive(1'b1, 1'b1, 16'h0004, 1'b1, 26'h1);
    repeat (5) begin
      tick();
      chk_st("halt_hold", 8'h2C, 1'b0, 1'b1);
    end

    rst = 1'b1;
    tick();
    chk_st("rst2", 8'h00, 1'b0, 1'b0);
    chk("rst2_fc", 32'(bus.fetch_count), 32'd0);
    chk_trace("rst2", 8'h00, 8'h00);

    // 0x00: branch -2 words -> 0x04 - 0x08 wraps to 0xFC
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'hFFFE, 1'b0, 26'h0);
    #1;
    chk("wrap_valid", 32'(bus.instr_valid), 32'd1);
    tick();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    chk_st("wrap", 8'hFC, 1'b1, 1'b0);
    chk("wrap_fc", 32'(bus.fetch_count), 32'd1);
    chk("wrap_plus4", 32'(bus.pc_plus4), 32'h00);
    chk_trace("wrap", 8'h00, 8'd1);
    tick();
    chk_st("wrap_seq", 8'h00, 1'b1, 1'b0);
    chk("wrap_seq_fc", 32'(bus.fetch_count), 32'd2);

    // Jump landing on HALT_ADDR halts, and that fetch is counted.
    drive(1'b1, 1'b0, 16'h0, 1'b1, 26'hB);
    tick();
    chk_st("jump_halt", 8'h2C, 1'b0, 1'b1);
    chk("jump_halt_fc", 32'(bus.fetch_count), 32'd3);
    chk_trace("jump_halt", 8'h00, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter and fetch-control stage that sits directly upstream of the instruction memory in the single-cycle MIPS datapath.
- Holds the PC and drives the memory's 8-bit byte address. Computes the next PC (sequential, beq-style branch, j-style jump), handles stall, and stops fetch at a program-end address.
- Passes the returned instruction downstream with a valid flag and counts retired fetches.

Parameters:
- ADDR_W, 8, PC/byte-address width; matches instruction memory address width.
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ADDR, 8'h2C, PC value that ends the program (one word past the last instruction).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  fetch enable; 0 = stall (hold PC).
- branch_taken  in  1  branch resolved taken for the current instruction.
- branch_offset  in  16  raw immediate field of the branch instruction.
- jump  in  1  current instruction is a jump.
- jump_target  in  26  raw target field of the jump instruction.
- instr_in  in  32  instruction returned by the instruction memory for pc_addr.
- pc_addr  out  ADDR_W  current PC; drives the instruction memory address.
- pc_plus4  out  ADDR_W  pc_addr+4, mod 2^ADDR_W.
- instr_out  out  32  instr_in passthrough.
- instr_valid  out  1  instr_out is a live instruction this cycle.
- halted  out  1  fetch has stopped.
- fetch_count  out  16  number of PC advances since reset.

Behaviour:
- Reset: on a rising edge with rst=1:
  - pc_addr=RESET_PC, state=RUN, fetch_count=0, halted=0.
  - rst overrides every other input.
- States:
  - RUN: normal fetch.
  - STALL: entered when en=0; holds PC.
  - HALT: terminal state.
- Transitions:
  - RUN/STALL go to STALL when en=0 and to RUN when en=1.
  - Any state with en=1 and next_pc==HALT_ADDR goes to HALT.
  - HALT exits only via rst.
- Outputs:
  - instr_valid = (state==RUN) && en && !rst.
  - halted = (state==HALT).
  - In HALT, pc_addr holds HALT_ADDR and instr_valid=0.
- Next-PC priority when en=1 and not HALT: jump > branch_taken > sequential.
  - Sequential: pc+4.
  - Branch: pc+4 + (sign_extend(branch_offset)<<2), truncated to ADDR_W (wraps mod 256).
  - Jump: {jump_target,2'b00} truncated to ADDR_W.
  - Result is registered into pc_addr at the next edge. Latency is 1 cycle from redirect input to new pc_addr.
- Stall (en=0):
  - pc_addr, fetch_count, and state-internal values hold.
  - branch_taken/jump are ignored.
- fetch_count increments by 1 on each PC load in RUN with en=1. It saturates at 16'hFFFF.
- Halt detection compares the computed next_pc, so a branch or jump landing on HALT_ADDR also halts. The fetch that redirects to HALT_ADDR is counted.
- Timing: instr_out/instr_valid are combinational within the cycle. There is no pipeline register.

Optional Feature:
- Macro: PC_REDIRECT_TRACE_EN.
- With the macro defined, two extra outputs are added:
  - last_redirect_pc [ADDR_W], reset 0: PC of the most recent instruction that caused a taken branch or jump.
  - redirect_count [8], reset 0: count of taken branches and jumps; wraps at 256.
  - Both update on the same edge as the PC load; both hold during stall/HALT.
- Without the macro: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package pc_fetch_pkg:
  - state enum {RUN, STALL, HALT}.
  - PC_STEP=4.
  - BR_SHIFT=2.
  - FETCH_CNT_W=16.
- One natural sub-module, next_pc_calc: purely combinational. Inputs are pc, jump, jump_target, branch_taken, branch_offset; outputs are next_pc and pc_plus4. The top keeps the register, FSM, and counters.

Test Plan:
- rst=1 for 2 cycles, then en=1 with no redirects -> pc_addr 0x00, 0x04, 0x08, 0x0C on successive cycles; fetch_count 0,1,2,3; instr_valid=1.
- At pc 0x10, branch_taken=1, branch_offset=16'h0004 -> pc_addr=0x24 next cycle; fetch_count +1.
- At pc 0x20, jump=1, jump_target=26'h4, branch_taken=1, branch_offset=16'h0008 -> pc_addr=0x10 (jump wins).
- At pc 0x14, en=0 for 3 cycles with jump=1 asserted -> pc_addr stays 0x14, fetch_count unchanged, instr_valid=0. Then en=1, no redirect -> 0x18.
- Sequential run reaching pc 0x28 -> next cycle pc_addr=0x2C, halted=1, instr_valid=0. Jump=1 is then ignored for 5 cycles. rst=1 -> pc_addr=0x00, halted=0.
- At pc 0x00, branch_taken=1, branch_offset=16'hFFFE -> pc_addr=0xFC (wrap). With PC_REDIRECT_TRACE_EN: last_redirect_pc=0x00, redirect_count=1.
